// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : MIPS IF stage: PC register, IF/ID latch, redirect and self-loop halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        id_jump,
   input  logic [31:0] id_jump_target,
   input  logic        ex_branch,
   input  logic [31:0] ex_branch_target,
   output logic [31:0] pc,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc_plus4,
   output logic        ifid_valid,
   output logic [31:0] fetch_count,
   output logic        halted
);

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   localparam logic [5:0] c_op_j = 6'b000010;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc_plus4;
   logic        r_ifid_valid;
   logic [31:0] r_fetch_count;
   logic        r_halted;

   logic [31:0] w_pc_plus4;
   logic        w_self_loop;

   assign w_pc_plus4  = r_pc + 32'd4;
   // A plain J whose pseudo-direct target is its own address ends the program.
   assign w_self_loop = (imem_instr[31:26] == c_op_j) &&
                        ({r_pc[31:28], imem_instr[25:0], 2'b00} == r_pc);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_RUN;
         r_pc            <= RESET_PC;
         r_ifid_instr    <= NOP;
         r_ifid_pc_plus4 <= 32'h0;
         r_ifid_valid    <= 1'b0;
         r_fetch_count   <= 32'h0;
         r_halted        <= 1'b0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (ex_branch) begin
                  r_pc         <= {ex_branch_target[31:2], 2'b00};
                  r_ifid_instr <= NOP;
                  r_ifid_valid <= 1'b0;
               end else if (stall) begin
                  r_pc         <= r_pc;
               end else if (id_jump) begin
                  r_pc         <= {id_jump_target[31:2], 2'b00};
                  r_ifid_instr <= NOP;
                  r_ifid_valid <= 1'b0;
               end else begin
                  r_ifid_instr    <= imem_instr;
                  r_ifid_pc_plus4 <= w_pc_plus4;
                  r_ifid_valid    <= 1'b1;
                  r_fetch_count   <= r_fetch_count + 32'd1;
                  if (w_self_loop) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_pc <= w_pc_plus4;
                  end
               end
            end
            S_HALT: begin
               // Loop instruction already delivered once; feed bubbles until reset.
               r_ifid_instr <= NOP;
               r_ifid_valid <= 1'b0;
               r_halted     <= 1'b1;
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

   assign imem_addr     = r_pc;
   assign pc            = r_pc;
   assign ifid_instr    = r_ifid_instr;
   assign ifid_pc_plus4 = r_ifid_pc_plus4;
   assign ifid_valid    = r_ifid_valid;
   assign fetch_count   = r_fetch_count;
   assign halted        = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Scoreboard bench for fetch_stage against a behavioural IF model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

   localparam logic [31:0] c_nop = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall;
   logic        id_jump;
   logic [31:0] id_jump_target;
   logic        ex_branch;
   logic [31:0] ex_branch_target;
   logic [31:0] pc;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_valid;
   logic [31:0] fetch_count;
   logic        halted;

   fetch_stage #(.RESET_PC(32'h0), .NOP(c_nop)) dut (
      .clk              (clk),
      .reset            (reset),
      .imem_addr        (imem_addr),
      .imem_instr       (imem_instr),
      .stall            (stall),
      .id_jump          (id_jump),
      .id_jump_target   (id_jump_target),
      .ex_branch        (ex_branch),
      .ex_branch_target (ex_branch_target),
      .pc               (pc),
      .ifid_instr       (ifid_instr),
      .ifid_pc_plus4    (ifid_pc_plus4),
      .ifid_valid       (ifid_valid),
      .fetch_count      (fetch_count),
      .halted           (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h3c01_6261;
         32'h0000_0004: mem_word = 32'h3424_6163;
         32'h0000_0008: mem_word = 32'hac04_0000;
         32'h0000_00D4: mem_word = 32'h0800_0035;   // j 0xD4
         32'h0000_00E0: mem_word = 32'h0C00_0038;   // jal 0xE0
         default:       mem_word = {16'h2000, a[15:0]};
      endcase
   endfunction

   always_comb imem_instr = mem_word(imem_addr);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] count;
      logic        halted;
   } exp_t;

   exp_t q_exp[$];

   logic [31:0] m_pc, m_instr, m_pc4, m_count;
   logic        m_valid, m_halted;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance the reference model by one edge and queue the expected outputs.
   task automatic model_step(input logic rs, input logic st, input logic jp,
                             input logic [31:0] jt, input logic br, input logic [31:0] bt);
      logic [31:0] w;
      exp_t e;
      if (rs) begin
         m_pc = 32'h0; m_instr = c_nop; m_pc4 = 32'h0; m_valid = 1'b0;
         m_count = 32'h0; m_halted = 1'b0;
      end else if (m_halted) begin
         m_instr = c_nop; m_valid = 1'b0;
      end else if (br) begin
         m_pc = bt & 32'hFFFF_FFFC; m_instr = c_nop; m_valid = 1'b0;
      end else if (st) begin
         m_pc = m_pc;
      end else if (jp) begin
         m_pc = jt & 32'hFFFF_FFFC; m_instr = c_nop; m_valid = 1'b0;
      end else begin
         w = mem_word(m_pc);
         m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_count = m_count + 32'd1;
         if (w[31:26] == 6'b000010 && {m_pc[31:28], w[25:0], 2'b00} == m_pc)
            m_halted = 1'b1;
         else
            m_pc = m_pc + 32'd4;
      end
      e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
      e.count = m_count; e.halted = m_halted;
      q_exp.push_back(e);
   endtask

   task automatic step(input logic rs, input logic st, input logic jp,
                       input logic [31:0] jt, input logic br, input logic [31:0] bt);
      exp_t e;
      reset = rs; stall = st; id_jump = jp; id_jump_target = jt;
      ex_branch = br; ex_branch_target = bt;
      model_step(rs, st, jp, jt, br, bt);
      @(posedge clk);
      #1;
      e = q_exp.pop_front();
      chk("pc", pc, e.pc);
      chk("imem_addr", imem_addr, e.pc);
      chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, e.valid});
      chk("ifid_instr", ifid_instr, e.instr);
      if (e.valid) chk("ifid_pc_plus4", ifid_pc_plus4, e.pc4);
      chk("fetch_count", fetch_count, e.count);
      chk("halted", {31'h0, halted}, {31'h0, e.halted});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      m_pc = 32'h0; m_instr = c_nop; m_pc4 = 32'h0; m_valid = 1'b0;
      m_count = 32'h0; m_halted = 1'b0;
      reset = 1'b1; stall = 1'b0; id_jump = 1'b0; id_jump_target = 32'h0;
      ex_branch = 1'b0; ex_branch_target = 32'h0;

      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_count", fetch_count, 32'h0);

      run(3);
      chk("seq_pc", pc, 32'h0000_000C);
      chk("seq_instr", ifid_instr, 32'hac04_0000);
      chk("seq_pc4", ifid_pc_plus4, 32'h0000_000C);
      chk("seq_count", fetch_count, 32'd3);

      run(1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("stall_pc", pc, 32'h0000_0010);
      chk("stall_count", fetch_count, 32'd4);
      run(1);
      chk("resume_pc4", ifid_pc_plus4, 32'h0000_0014);

      step(1'b0, 1'b1, 1'b1, 32'h0000_00D8, 1'b1, 32'h0000_0128);
      chk("br_prio_pc", pc, 32'h0000_0128);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0196, 1'b0, 32'h0);
      chk("jmp_align_pc", pc, 32'h0000_0194);

      step(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
      chk("stall_jmp_pc", pc, 32'h0000_0194);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
      chk("jmp_pc", pc, 32'h0000_0040);

      step(1'b0, 1'b0, 1'b1, 32'h0000_00E0, 1'b0, 32'h0);
      run(1);
      chk("jal_self_pc", pc, 32'h0000_00E4);

      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      run(1);
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_pc4", ifid_pc_plus4, 32'h0);

      step(1'b0, 1'b0, 1'b1, 32'h0000_00D4, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b1, 32'h0000_00D4, 1'b0, 32'h0);
      chk("noh_redirect", {31'h0, halted}, 32'h0);
      run(1);
      chk("halt_instr", ifid_instr, 32'h0800_0035);
      chk("halt_flag", {31'h0, halted}, 32'h1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0300);
      chk("halt_br_pc", pc, 32'h0000_00D4);
      run(3);

      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("rst_halt_pc", pc, 32'h0);
      chk("rst_halt_flag", {31'h0, halted}, 32'h0);

      for (int i = 0; i < 60; i++) begin
         step(1'b0, ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
              {24'h0, 8'($urandom_range(0, 255))}, ($urandom_range(0, 8) == 0),
              {24'h0, 8'($urandom_range(0, 255))});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
